// File: rtl/layer_serializer.sv
// Double-buffered parallel-to-serial bridge between NN layers: captures nn per-neuron words, replays one per cycle.
// Optional running argmax over each emitted frame, enabled by defining SERIALIZER_ARGMAX_EN.
module layer_serializer #(
    parameter int nn         = 10,
    parameter int data_width = 16,
    localparam int idx_w     = (nn > 1) ? $clog2(nn) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [nn-1:0]            i_valid,
    input  logic [nn*data_width-1:0] x_in_flat,
    output logic                     x_valid,
    output logic [data_width-1:0]    x_out,
    output logic                     frame_last,
    output logic                     overflow
`ifdef SERIALIZER_ARGMAX_EN
    ,
    output logic [idx_w-1:0]         class_out,
    output logic                     class_valid
`endif
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [idx_w-1:0] last_idx = idx_w'(nn - 1);

    state_t                state_q, state_d;
    logic [nn-1:0]         got;
    logic [idx_w-1:0]      idx;
    logic [idx_w-1:0]      next_idx;
    logic [data_width-1:0] cap_data [nn];
    logic [data_width-1:0] sh_data  [nn];
    logic                  last_word;
    logic                  transfer;

    // idx always names the word currently on x_out, so "emitting nn-1" is a register compare.
    assign last_word = (state_q == SHIFT) && (idx == last_idx);
    assign transfer  = (&got) && ((state_q == IDLE) || last_word);
    assign next_idx  = idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (transfer) state_d = SHIFT;
            SHIFT:   if (last_word && !transfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the word buffers carry no reset; clearing got and returning to IDLE already invalidates them.
    always_ff @(posedge clk) begin
        if (transfer) sh_data <= cap_data;
        for (int j = 0; j < nn; j++) begin
            if (i_valid[j] && (transfer || !got[j]))
                cap_data[j] <= x_in_flat[j*data_width +: data_width];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            got        <= '0;
            idx        <= '0;
            x_valid    <= 1'b0;
            x_out      <= '0;
            frame_last <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            got      <= transfer ? i_valid : (got | i_valid);
            overflow <= overflow | (|(i_valid & got & {nn{~transfer}}));
            if (transfer) begin
                idx        <= '0;
                x_valid    <= 1'b1;
                x_out      <= cap_data[0];
                frame_last <= 1'b0;
            end else if ((state_q == SHIFT) && !last_word) begin
                idx        <= next_idx;
                x_valid    <= 1'b1;
                x_out      <= sh_data[next_idx];
                frame_last <= (next_idx == last_idx);
            end else begin
                x_valid    <= 1'b0;
                frame_last <= 1'b0;
            end
        end
    end

`ifdef SERIALIZER_ARGMAX_EN
    logic signed [data_width-1:0] run_max;
    logic [idx_w-1:0]             run_idx;
    logic                         word_gt;

    // Strictly greater only, so ties keep the lower index.
    assign word_gt = $signed(x_out) > run_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            run_max     <= '0;
            run_idx     <= '0;
            class_out   <= '0;
            class_valid <= 1'b0;
        end else begin
            class_valid <= x_valid && frame_last;
            if (x_valid && ((idx == '0) || word_gt)) begin
                run_max <= $signed(x_out);
                run_idx <= idx;
            end
            if (x_valid && frame_last)
                class_out <= word_gt ? idx : run_idx;
        end
    end
`endif

endmodule

// File: tb/tb_layer_serializer.sv
// Directed self-checking bench for layer_serializer (nn=10, 16-bit words).
module tb_layer_serializer;

    localparam int nn = 10;
    localparam int dw = 16;
    localparam int iw = $clog2(nn);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [nn-1:0]    i_valid = '0;
    logic [nn*dw-1:0] x_in_flat = '0;
    logic             x_valid;
    logic [dw-1:0]    x_out;
    logic             frame_last;
    logic             overflow;
`ifdef SERIALIZER_ARGMAX_EN
    logic [iw-1:0]    class_out;
    logic             class_valid;
`endif

    layer_serializer #(.nn(nn), .data_width(dw)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .x_in_flat  (x_in_flat),
        .x_valid    (x_valid),
        .x_out      (x_out),
        .frame_last (frame_last),
        .overflow   (overflow)
`ifdef SERIALIZER_ARGMAX_EN
        ,
        .class_out  (class_out),
        .class_valid(class_valid)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [dw-1:0] exp_w [nn];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs default to idle for the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
        i_valid = '0;
    endtask

    task automatic put(input int j, input logic [dw-1:0] v);
        x_in_flat[j*dw +: dw] = v;
        exp_w[j] = v;
    endtask

    // Called in cycle T (last bit driven): checks the gap cycle T+1 and words in T+2..T+11.
    task automatic expect_frame(input string tag);
        step();
        check({tag, "_gap_valid"}, 32'(x_valid), 32'd0);
        for (int k = 0; k < nn; k++) begin
            step();
            check($sformatf("%s_valid%0d", tag, k), 32'(x_valid), 32'd1);
            check($sformatf("%s_word%0d", tag, k), 32'(x_out), 32'(exp_w[k]));
            check($sformatf("%s_last%0d", tag, k), 32'(frame_last), 32'(k == nn - 1));
        end
    endtask

    initial begin
        int order [nn];
        int vcount;

        // Reset state
        repeat (3) step();
        check("rst_valid", 32'(x_valid), 32'd0);
        check("rst_last", 32'(frame_last), 32'd0);
        check("rst_xout", 32'(x_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
`ifdef SERIALIZER_ARGMAX_EN
        check("rst_cvalid", 32'(class_valid), 32'd0);
        check("rst_class", 32'(class_out), 32'd0);
`endif
        rst = 1'b0;
        step();

        // Simultaneous capture: all bits in one cycle
        for (int j = 0; j < nn; j++) put(j, 16'(100 + j));
        i_valid = '1;
        expect_frame("simul");
        step();
        check("simul_after_valid", 32'(x_valid), 32'd0);
        check("simul_ovf", 32'(overflow), 32'd0);
        check("simul_hold_xout", 32'(x_out), 32'd109);

        // Staggered arrival, one bit per cycle in order 9,3,0,1,2,4,...
        order = '{9, 3, 0, 1, 2, 4, 5, 6, 7, 8};
        for (int j = 0; j < nn; j++) put(j, 16'(200 + j));
        vcount = 0;
        for (int i = 0; i < nn; i++) begin
            step();
            if (x_valid) vcount++;
            i_valid[order[i]] = 1'b1;
        end
        check("stagger_early_valid", 32'(vcount), 32'd0);
        expect_frame("stagger");

        // Back-to-back: frame B completes while frame A shifts
        for (int j = 0; j < nn; j++) put(j, 16'(300 + j));
        step();
        i_valid = '1;
        step();
        check("b2b_gap_valid", 32'(x_valid), 32'd0);
        for (int k = 0; k < 2 * nn; k++) begin
            step();
            check($sformatf("b2b_valid%0d", k), 32'(x_valid), 32'd1);
            check($sformatf("b2b_word%0d", k), 32'(x_out),
                  32'((k < nn) ? 300 + k : 400 + k - nn));
            check($sformatf("b2b_last%0d", k), 32'(frame_last),
                  32'((k == nn - 1) || (k == 2 * nn - 1)));
            if (k == 2) begin
                for (int j = 0; j < nn; j++) x_in_flat[j*dw +: dw] = 16'(400 + j);
                i_valid = '1;
            end
        end
        step();
        check("b2b_after_valid", 32'(x_valid), 32'd0);
        check("b2b_ovf", 32'(overflow), 32'd0);

`ifdef SERIALIZER_ARGMAX_EN
        // Argmax: signed compare, tie keeps lower index
        put(0, 16'h0005); put(1, 16'hFFFD); put(2, 16'h7FFF); put(3, 16'h7FFF);
        put(4, 16'h8000); put(5, 16'h0001); put(6, 16'h0002); put(7, 16'h0003);
        put(8, 16'h0004); put(9, 16'h0000);
        step();
        i_valid = '1;
        expect_frame("amax");
        check("amax_cvalid_at_last", 32'(class_valid), 32'd0);
        step();
        check("amax_cvalid", 32'(class_valid), 32'd1);
        check("amax_class", 32'(class_out), 32'd2);
        step();
        check("amax_cvalid_pulse", 32'(class_valid), 32'd0);
`endif

        // Overflow: neuron 4 reports twice before the frame completes
        step();
        put(4, 16'h0011);
        i_valid[4] = 1'b1;
        step();
        x_in_flat[4*dw +: dw] = 16'h0022;
        i_valid[4] = 1'b1;
        step();
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_no_valid", 32'(x_valid), 32'd0);
        for (int j = 0; j < nn; j++) if (j != 4) put(j, 16'(500 + j));
        i_valid = '1;
        i_valid[4] = 1'b0;
        expect_frame("ovf");
        step();
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset during word 3; a half-captured next frame must be discarded too
        for (int j = 0; j < nn; j++) put(j, 16'(600 + j));
        i_valid = '1;
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("mid_word%0d", k), 32'(x_out), 32'(600 + k));
            if (k == 1) begin
                for (int j = 0; j < 5; j++) x_in_flat[j*dw +: dw] = 16'(700 + j);
                i_valid = 10'h01F;
            end
        end
        check("mid_ovf_before", 32'(overflow), 32'd1);
        rst = 1'b1;
        step();
        check("mid_rst_valid", 32'(x_valid), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_xout", 32'(x_out), 32'd0);
        rst = 1'b0;
        step();
        for (int j = 5; j < nn; j++) x_in_flat[j*dw +: dw] = 16'(700 + j);
        i_valid = 10'h3E0;
        vcount = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (x_valid) vcount++;
        end
        check("mid_no_emit", 32'(vcount), 32'd0);

        // A complete frame after the reset flows normally
        for (int j = 0; j < 5; j++) put(j, 16'(800 + j));
        for (int j = 5; j < nn; j++) exp_w[j] = 16'(700 + j);
        i_valid = 10'h01F;
        expect_frame("post");
        check("post_ovf", 32'(overflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
